// File: rtl/idu_issue_ctrl_if.sv
// Decode-stage issue controller bus: fetch handshake, IDU link, CU issue handshake,
// writeback, flush and status. The controller uses the master view.
interface idu_issue_ctrl_if;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic [31:0] idu_instr;
    logic        idu_start;
    logic [5:0]  idu_op;
    logic [4:0]  idu_rd;
    logic [4:0]  idu_rs1;
    logic [4:0]  idu_rs2;
    logic        idu_use_rs1;
    logic        idu_use_rs2;
    logic        idu_writes_rd;
    logic        idu_invalid;
    logic        cu_valid;
    logic        cu_ready;
    logic [5:0]  cu_op;
    logic [4:0]  cu_rd;
    logic [4:0]  cu_rs1;
    logic [4:0]  cu_rs2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic        illegal_instr;
    logic [31:0] busy_map;

    modport master (
        input  fetch_valid, fetch_instr, idu_op, idu_rd, idu_rs1, idu_rs2,
               idu_use_rs1, idu_use_rs2, idu_writes_rd, idu_invalid,
               cu_ready, wb_valid, wb_rd, flush,
        output fetch_ready, idu_instr, idu_start, cu_valid, cu_op, cu_rd, cu_rs1,
               cu_rs2, stall, illegal_instr, busy_map
    );

    modport slave (
        output fetch_valid, fetch_instr, idu_op, idu_rd, idu_rs1, idu_rs2,
               idu_use_rs1, idu_use_rs2, idu_writes_rd, idu_invalid,
               cu_ready, wb_valid, wb_rd, flush,
        input  fetch_ready, idu_instr, idu_start, cu_valid, cu_op, cu_rd, cu_rs1,
               cu_rs2, stall, illegal_instr, busy_map
    );
endinterface

// File: rtl/idu_issue_ctrl.sv
// Decode-stage sequencer: fetch accept, IDU decode wait, RAW/WAW scoreboard check,
// and valid/ready issue to the CU. One instruction in flight at a time.
module idu_issue_ctrl #(
    parameter int DECODE_LAT      = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              soc_clk,
    input  logic              reset,
    idu_issue_ctrl_if.master  bus
);
    localparam int CNT_W = (DECODE_LAT > 1) ? $clog2(DECODE_LAT) : 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {IDLE, DECODE, CHECK, ISSUE, TRAP} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        instr_reg;
    logic [5:0]         op_reg;
    logic [4:0]         rd_reg, rs1_reg, rs2_reg;
    logic               use_rs1_reg, use_rs2_reg, writes_rd_reg;
    logic [31:0]        busy_reg, busy_next;
    logic [OUT_W-1:0]   outstanding_reg, outstanding_next;

    logic accept, capture, rd_writer, at_limit, hazard, issue_fire, sb_set, sb_clr;

    assign accept     = (state_reg == IDLE) && bus.fetch_valid && !bus.flush;
    assign capture    = (state_reg == DECODE) && (cnt_reg == '0);
    // x0 is never tracked, so an x0 writer neither waits on nor consumes a slot
    assign rd_writer  = writes_rd_reg && (rd_reg != 5'd0);
    assign at_limit   = (outstanding_reg == OUT_W'(MAX_OUTSTANDING));
    assign hazard     = (use_rs1_reg && busy_reg[rs1_reg])
                      | (use_rs2_reg && busy_reg[rs2_reg])
                      | (rd_writer && (busy_reg[rd_reg] || at_limit));
    assign issue_fire = (state_reg == ISSUE) && bus.cu_ready && !bus.flush;
    assign sb_set     = issue_fire && rd_writer;
    assign sb_clr     = bus.wb_valid && (bus.wb_rd != 5'd0) && busy_reg[bus.wb_rd];

    // Set takes priority over a same-cycle clear of the same register
    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
        assign busy_next[gi] = (sb_set && (rd_reg == 5'(gi)))    ? 1'b1 :
                               (sb_clr && (bus.wb_rd == 5'(gi))) ? 1'b0 :
                                                                   busy_reg[gi];
    end

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({sb_set, sb_clr})
            2'b10:   outstanding_next = outstanding_reg + OUT_W'(1);
            2'b01:   outstanding_next = outstanding_reg - OUT_W'(1);
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        bus.fetch_ready   = 1'b0;
        bus.idu_start     = 1'b0;
        bus.cu_valid      = 1'b0;
        bus.stall         = 1'b0;
        bus.illegal_instr = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.fetch_ready = !bus.flush;
                if (accept) begin
                    cnt_next   = CNT_W'(DECODE_LAT - 1);
                    state_next = DECODE;
                end
            end
            DECODE: begin
                bus.idu_start = (cnt_reg == CNT_W'(DECODE_LAT - 1));
                if (cnt_reg == '0) state_next = bus.idu_invalid ? TRAP : CHECK;
                else               cnt_next   = cnt_reg - CNT_W'(1);
            end
            CHECK: begin
                bus.stall = hazard;
                if (!hazard) state_next = ISSUE;
            end
            ISSUE: begin
                bus.cu_valid = 1'b1;
                if (bus.cu_ready) state_next = IDLE;
            end
            TRAP: begin
                bus.illegal_instr = 1'b1;
                state_next        = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            instr_reg       <= '0;
            op_reg          <= '0;
            rd_reg          <= '0;
            rs1_reg         <= '0;
            rs2_reg         <= '0;
            use_rs1_reg     <= 1'b0;
            use_rs2_reg     <= 1'b0;
            writes_rd_reg   <= 1'b0;
            busy_reg        <= '0;
            outstanding_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            busy_reg        <= busy_next;
            outstanding_reg <= outstanding_next;
            if (accept) instr_reg <= bus.fetch_instr;
            if (capture) begin
                op_reg        <= bus.idu_op;
                rd_reg        <= bus.idu_rd;
                rs1_reg       <= bus.idu_rs1;
                rs2_reg       <= bus.idu_rs2;
                use_rs1_reg   <= bus.idu_use_rs1;
                use_rs2_reg   <= bus.idu_use_rs2;
                writes_rd_reg <= bus.idu_writes_rd;
            end
        end
    end

    assign bus.idu_instr = instr_reg;
    assign bus.cu_op     = op_reg;
    assign bus.cu_rd     = rd_reg;
    assign bus.cu_rs1    = rs1_reg;
    assign bus.cu_rs2    = rs2_reg;
    assign bus.busy_map  = busy_reg;
endmodule

// File: tb/tb_idu_issue_ctrl.sv
// Scoreboard bench for idu_issue_ctrl: directed stimulus pushes expected CU issues and
// traps into a queue; a negedge monitor pops and compares on every issue/trap event.
module tb_idu_issue_ctrl;
    logic soc_clk;
    logic reset;
    idu_issue_ctrl_if bus ();

    idu_issue_ctrl #(.DECODE_LAT(1), .MAX_OUTSTANDING(4)) dut (
        .soc_clk (soc_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    int passed = 0;
    int total  = 0;
    logic [21:0] exp_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: every CU transfer or trap pulse must match the head of the queue
    initial begin
        logic [21:0] e;
        forever begin
            @(negedge soc_clk);
            if (!reset && bus.cu_valid && bus.cu_ready && !bus.flush) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                $display("issue op=%0d rd=%0d rs1=%0d rs2=%0d", bus.cu_op, bus.cu_rd,
                         bus.cu_rs1, bus.cu_rs2);
                chk("issue_fields", {10'd0, 1'b0, bus.cu_op, bus.cu_rd, bus.cu_rs1, bus.cu_rs2},
                    {10'd0, e});
            end
            if (!reset && bus.illegal_instr) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                $display("trap instr=0x%08h", bus.idu_instr);
                chk("trap_event", {10'd0, 1'b1, 21'd0}, {10'd0, e});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [31:0] instr, input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic wr, input logic inv, input bit push);
        int n = 0;
        bus.idu_op = op;  bus.idu_rd = rd;  bus.idu_rs1 = rs1;  bus.idu_rs2 = rs2;
        bus.idu_use_rs1 = u1;  bus.idu_use_rs2 = u2;  bus.idu_writes_rd = wr;
        bus.idu_invalid = inv;
        bus.fetch_instr = instr;
        bus.fetch_valid = 1'b1;
        while (!bus.fetch_ready && n < 20) begin
            @(negedge soc_clk);
            n++;
        end
        chk("fetch_ready_wait", {31'd0, bus.fetch_ready}, 32'd1);
        if (push) exp_q.push_back(inv ? {1'b1, 21'd0} : {1'b0, op, rd, rs1, rs2});
        @(posedge soc_clk);
        #1 bus.fetch_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.cu_valid && n < 30) begin
            @(negedge soc_clk);
            n++;
        end
        chk("cu_valid_wait", {31'd0, bus.cu_valid}, 32'd1);
    endtask

    task automatic wait_xfer();
        wait_valid();
        @(posedge soc_clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = r;
        @(posedge soc_clk);
        #1 bus.wb_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.fetch_valid = 0; bus.fetch_instr = 0; bus.idu_op = 0; bus.idu_rd = 0;
        bus.idu_rs1 = 0; bus.idu_rs2 = 0; bus.idu_use_rs1 = 0; bus.idu_use_rs2 = 0;
        bus.idu_writes_rd = 0; bus.idu_invalid = 0; bus.cu_ready = 0;
        bus.wb_valid = 0; bus.wb_rd = 0; bus.flush = 0;

        // Reset values
        repeat (3) @(negedge soc_clk);
        chk("rst_cu_valid",    {31'd0, bus.cu_valid}, 32'd0);
        chk("rst_idu_start",   {31'd0, bus.idu_start}, 32'd0);
        chk("rst_stall",       {31'd0, bus.stall}, 32'd0);
        chk("rst_illegal",     {31'd0, bus.illegal_instr}, 32'd0);
        chk("rst_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
        chk("rst_busy_map",    bus.busy_map, 32'd0);
        chk("rst_idu_instr",   bus.idu_instr, 32'd0);
        @(posedge soc_clk);
        #1 reset = 1'b0;

        // addi x5,x0,5: issue three cycles after accept
        bus.cu_ready = 1'b1;
        send(32'h0050_0293, 6'd18, 5'd5, 5'd0, 5'd0, 1, 0, 1, 0, 1);
        @(negedge soc_clk);
        chk("addi_idu_start", {31'd0, bus.idu_start}, 32'd1);
        chk("addi_idu_instr", bus.idu_instr, 32'h0050_0293);
        n = 1;
        while (!bus.cu_valid && n < 20) begin
            @(negedge soc_clk);
            n++;
        end
        chk("addi_latency", n, 32'd3);
        @(posedge soc_clk); #1;
        @(negedge soc_clk);
        chk("addi_busy_map", bus.busy_map, 32'h20);
        chk("addi_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);

        // add x6,x5,x1 stalls on busy x5 until its writeback
        send(32'h0012_8333, 6'd1, 5'd6, 5'd5, 5'd1, 1, 1, 1, 0, 1);
        repeat (4) @(negedge soc_clk);
        chk("raw_stall", {31'd0, bus.stall}, 32'd1);
        chk("raw_no_valid", {31'd0, bus.cu_valid}, 32'd0);
        @(posedge soc_clk); #1;
        wb(5'd5);
        @(negedge soc_clk);
        chk("raw_stall_cleared", {31'd0, bus.stall}, 32'd0);
        chk("raw_busy_after_wb", bus.busy_map, 32'h0);
        @(negedge soc_clk);
        chk("raw_issue_after_wb", {31'd0, bus.cu_valid}, 32'd1);
        @(posedge soc_clk); #1;
        @(negedge soc_clk);
        chk("raw_busy_map", bus.busy_map, 32'h40);
        @(posedge soc_clk); #1;
        wb(5'd6);

        // Invalid opcode traps for one cycle
        send(32'h0000_007F, 6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
        @(negedge soc_clk);
        @(negedge soc_clk);
        chk("trap_illegal", {31'd0, bus.illegal_instr}, 32'd1);
        chk("trap_no_valid", {31'd0, bus.cu_valid}, 32'd0);
        @(negedge soc_clk);
        chk("trap_pulse_end", {31'd0, bus.illegal_instr}, 32'd0);
        chk("trap_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
        chk("trap_busy_map", bus.busy_map, 32'h0);

        // Fill the outstanding limit with x1..x4, fifth writer stalls
        for (int r = 1; r <= 4; r++) begin
            send(32'h13 | (r << 7), 6'd18, 5'(r), 5'd0, 5'd0, 1, 0, 1, 0, 1);
            wait_xfer();
        end
        send(32'h13 | (8 << 7), 6'd18, 5'd8, 5'd0, 5'd0, 1, 0, 1, 0, 1);
        repeat (5) @(negedge soc_clk);
        chk("limit_stall", {31'd0, bus.stall}, 32'd1);
        chk("limit_busy_map", bus.busy_map, 32'h1E);
        @(posedge soc_clk); #1;
        wb(5'd1);
        wait_xfer();
        @(negedge soc_clk);
        chk("limit_busy_after", bus.busy_map, 32'h11C);
        @(posedge soc_clk); #1;
        wb(5'd2); wb(5'd3); wb(5'd4); wb(5'd8);
        @(negedge soc_clk);
        chk("limit_drained", bus.busy_map, 32'h0);

        // Flush in ISSUE with cu_ready high: nothing issues, no busy bit
        bus.cu_ready = 1'b0;
        @(posedge soc_clk); #1;
        send(32'h13 | (9 << 7), 6'd18, 5'd9, 5'd0, 5'd0, 1, 0, 1, 0, 0);
        wait_valid();
        @(posedge soc_clk);
        #1 bus.cu_ready = 1'b1; bus.flush = 1'b1;
        @(posedge soc_clk);
        #1 bus.flush = 1'b0;
        @(negedge soc_clk);
        chk("flush_cu_valid", {31'd0, bus.cu_valid}, 32'd0);
        chk("flush_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
        chk("flush_busy_map", bus.busy_map, 32'h0);

        // Reset mid-DECODE discards the instruction and the scoreboard
        @(posedge soc_clk); #1;
        send(32'h13 | (10 << 7), 6'd18, 5'd10, 5'd0, 5'd0, 1, 0, 1, 0, 1);
        wait_xfer();
        @(negedge soc_clk);
        chk("pre_reset_busy", bus.busy_map, 32'h400);
        @(posedge soc_clk); #1;
        send(32'h13 | (11 << 7), 6'd18, 5'd11, 5'd0, 5'd0, 1, 0, 1, 0, 0);
        @(negedge soc_clk);
        chk("mid_decode_start", {31'd0, bus.idu_start}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mrst_cu_valid", {31'd0, bus.cu_valid}, 32'd0);
        chk("mrst_idu_start", {31'd0, bus.idu_start}, 32'd0);
        chk("mrst_stall", {31'd0, bus.stall}, 32'd0);
        chk("mrst_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
        chk("mrst_busy_map", bus.busy_map, 32'h0);
        chk("mrst_idu_instr", bus.idu_instr, 32'h0);
        chk("mrst_cu_rd", {27'd0, bus.cu_rd}, 32'd0);
        @(posedge soc_clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge soc_clk);
        chk("post_reset_idle", {31'd0, bus.cu_valid}, 32'd0);

        // Same-cycle writeback of x7 and issue of x7: set wins
        bus.cu_ready = 1'b0;
        @(posedge soc_clk); #1;
        send(32'h13 | (7 << 7), 6'd18, 5'd7, 5'd0, 5'd0, 1, 0, 1, 0, 1);
        wait_valid();
        @(posedge soc_clk);
        #1 bus.cu_ready = 1'b1; bus.wb_valid = 1'b1; bus.wb_rd = 5'd7;
        @(posedge soc_clk);
        #1 bus.wb_valid = 1'b0;
        @(negedge soc_clk);
        chk("same_cycle_busy", bus.busy_map, 32'h80);
        @(posedge soc_clk); #1;
        wb(5'd7);
        @(negedge soc_clk);
        chk("final_busy", bus.busy_map, 32'h0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
